gate_net_input_packer: RTL and testbench

Upstream feeder for the 49-input binary gate-network classifiers. It accepts a serial grayscale pixel stream with a valid/ready handshake and binarizes each pixel against a programmable threshold. It packs each 7x7 frame into one N_PIX-bit vector and presents it through a registered valid/ready output. The output drives the classifier's in_bits directly. Internally the block is double-buffered: one frame assembles while the previous frame waits for the consumer.

---
 rtl/gate_net_input_packer.sv | 197 +++++++++++++++++++
 tb/tb_gate_net_input_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_net_input_packer.sv
// ---------------------------------------------------------------------------
// gate_net_input_packer
//
// Front end for the 49-input binary gate-network classifiers. Grayscale
// pixels arrive one per handshake. Each pixel is binarized against a
// programmable threshold and written into an assembly vector. A complete
// frame is then presented on in_bits behind a registered valid/ready
// handshake. The assembly vector and the output register form a double
// buffer, so the next frame can assemble while the consumer is stalled.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pix_valid/pix_ready   pixel stream handshake
//   pix_data              unsigned pixel intensity (PIX_W bits)
//   pix_last              marks the final pixel of a frame
//   cfg_thresh_we         threshold write strobe
//   cfg_thresh            new threshold value
//   bits_valid/bits_ready frame output handshake
//   in_bits               packed frame; pixel k is bit k
//   frame_err             one-cycle pulse on a short or long frame
//   frame_count           frames delivered, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module gate_net_input_packer #(
    parameter int PIX_W      = 8,
    parameter int N_PIX      = 49,
    parameter int THRESH_RST = 128,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    input  logic             cfg_thresh_we,
    input  logic [PIX_W-1:0] cfg_thresh,
    output logic             bits_valid,
    input  logic             bits_ready,
    output logic [N_PIX-1:0] in_bits,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_count
);

    localparam int IDX_W = $clog2(N_PIX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIX - 1);

    // FILL: assembling a frame. HOLD: complete frame waiting for the output
    // slot. DROP: discarding the tail of an over-long frame.
    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [IDX_W-1:0]   idx_q,         idx_d;
    logic [N_PIX-1:0]   asm_q,         asm_d;
    logic [PIX_W-1:0]   thresh_q,      thresh_d;
    logic               drop_pend_q,   drop_pend_d;
    logic               bits_valid_q,  bits_valid_d;
    logic [N_PIX-1:0]   in_bits_q,     in_bits_d;
    logic               frame_err_q,   frame_err_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;

    logic               pix_bit;
    logic               accept;
    logic               xfer;
    logic               slot_free;
    logic               load;
    logic [N_PIX-1:0]   load_val;
    logic [N_PIX-1:0]   full_frame;

    assign pix_ready   = (state_q != S_HOLD);
    assign bits_valid  = bits_valid_q;
    assign in_bits     = in_bits_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        asm_d         = asm_q;
        thresh_d      = thresh_q;
        drop_pend_d   = drop_pend_q;
        bits_valid_d  = bits_valid_q;
        in_bits_d     = in_bits_q;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        load          = 1'b0;
        load_val      = '0;

        // Compare uses the threshold in effect before any write this cycle.
        pix_bit   = (pix_data >= thresh_q);
        accept    = pix_valid && pix_ready;
        xfer      = bits_valid_q && bits_ready;
        // The output register can take a new frame if it is empty or is
        // being emptied on this very edge.
        slot_free = !bits_valid_q || bits_ready;

        full_frame            = asm_q;
        full_frame[N_PIX-1]   = pix_bit;

        if (cfg_thresh_we) begin
            thresh_d = cfg_thresh;
        end

        if (xfer) begin
            frame_count_d = frame_count_q + CNT_W'(1);
        end

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d       = '0;
                        // Missing pix_last on the final pixel: long frame.
                        frame_err_d = !pix_last;
                        if (slot_free) begin
                            load     = 1'b1;
                            load_val = full_frame;
                            asm_d    = '0;
                            state_d  = pix_last ? S_FILL : S_DROP;
                        end else begin
                            asm_d       = full_frame;
                            drop_pend_d = !pix_last;
                            state_d     = S_HOLD;
                        end
                    end else if (pix_last) begin
                        // Short frame: throw away what was assembled.
                        idx_d       = '0;
                        asm_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        asm_d[idx_q] = pix_bit;
                        idx_d        = idx_q + 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (slot_free) begin
                    load        = 1'b1;
                    load_val    = asm_q;
                    asm_d       = '0;
                    drop_pend_d = 1'b0;
                    state_d     = drop_pend_q ? S_DROP : S_FILL;
                end
            end

            S_DROP: begin
                if (accept && pix_last) begin
                    idx_d   = '0;
                    state_d = S_FILL;
                end
            end

            default: begin
                state_d = S_FILL;
                idx_d   = '0;
            end
        endcase

        // A frame loaded on the same edge as a transfer keeps bits_valid
        // high, giving back-to-back delivery without a bubble.
        if (load) begin
            bits_valid_d = 1'b1;
            in_bits_d    = load_val;
        end else if (xfer) begin
            bits_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            idx_q         <= '0;
            asm_q         <= '0;
            thresh_q      <= PIX_W'(THRESH_RST);
            drop_pend_q   <= 1'b0;
            bits_valid_q  <= 1'b0;
            in_bits_q     <= '0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            asm_q         <= asm_d;
            thresh_q      <= thresh_d;
            drop_pend_q   <= drop_pend_d;
            bits_valid_q  <= bits_valid_d;
            in_bits_q     <= in_bits_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_gate_net_input_packer.sv
// ---------------------------------------------------------------------------
// tb_gate_net_input_packer
//
// Drives directed scenarios and randomized frames into gate_net_input_packer.
// A behavioural model built from pixel queues and a pending-frame queue
// predicts every output each cycle; a few literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_gate_net_input_packer;

    localparam int PIX_W = 8;
    localparam int N_PIX = 49;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data = '0;
    logic             pix_last = 1'b0;
    logic             cfg_thresh_we = 1'b0;
    logic [PIX_W-1:0] cfg_thresh = '0;
    logic             bits_valid;
    logic             bits_ready = 1'b0;
    logic [N_PIX-1:0] in_bits;
    logic             frame_err;
    logic [CNT_W-1:0] frame_count;

    int  errors = 0;
    int  checks = 0;
    bit  rand_br = 1'b0;
    bit  rand_gap = 1'b0;

    gate_net_input_packer #(
        .PIX_W(PIX_W), .N_PIX(N_PIX), .THRESH_RST(128), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last),
        .cfg_thresh_we(cfg_thresh_we), .cfg_thresh(cfg_thresh),
        .bits_valid(bits_valid), .bits_ready(bits_ready),
        .in_bits(in_bits), .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               col[$];          // binarized pixels of the frame in progress
    logic [N_PIX-1:0] held[$];         // complete frame waiting for the output
    bit               pend_drop;
    bit               dropping;
    bit               m_valid;
    logic [N_PIX-1:0] m_bits;
    bit               m_err;
    logic [CNT_W-1:0] m_cnt;
    logic [PIX_W-1:0] m_th;

    always @(posedge clk or negedge rst_n) begin
        bit acc, xfer, slot, deliver;
        logic [N_PIX-1:0] fr, f;
        if (!rst_n) begin
            col.delete(); held.delete();
            pend_drop = 0; dropping = 0; m_valid = 0; m_bits = '0;
            m_err = 0; m_cnt = '0; m_th = 8'd128;
        end else begin
            acc     = pix_valid && (held.size() == 0);
            xfer    = m_valid && bits_ready;
            slot    = !m_valid || bits_ready;
            deliver = 0;
            f       = '0;
            m_err   = 0;
            if (acc) begin
                if (dropping) begin
                    if (pix_last) dropping = 0;
                end else begin
                    col.push_back(pix_data >= m_th);
                    if (col.size() == N_PIX) begin
                        fr = '0;
                        foreach (col[i]) fr[i] = col[i];
                        col.delete();
                        if (!pix_last) m_err = 1;
                        if (slot) begin
                            deliver = 1; f = fr; dropping = !pix_last;
                        end else begin
                            held.push_back(fr); pend_drop = !pix_last;
                        end
                    end else if (pix_last) begin
                        col.delete();
                        m_err = 1;
                    end
                end
            end else if (held.size() != 0 && slot) begin
                deliver  = 1;
                f        = held.pop_front();
                dropping = pend_drop;
            end
            if (xfer) begin
                $display("frame %0d delivered bits=%h", m_cnt, m_bits);
                m_cnt++;
            end
            if (deliver) begin
                m_valid = 1; m_bits = f;
            end else if (xfer) begin
                m_valid = 0;
            end
            if (cfg_thresh_we) m_th = cfg_thresh;
        end
    end

    // Compare DUT against model away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pix_ready",   64'(pix_ready),   64'(held.size() == 0));
            chk("bits_valid",  64'(bits_valid),  64'(m_valid));
            chk("in_bits",     64'(in_bits),     64'(m_bits));
            chk("frame_err",   64'(frame_err),   64'(m_err));
            chk("frame_count", 64'(frame_count), 64'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rand_br) bits_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [7:0] d, input bit last, input bit we, input logic [7:0] th);
        int n = 0;
        bit r;
        pix_valid = 1'b1; pix_data = d; pix_last = last;
        cfg_thresh_we = we; cfg_thresh = th;
        forever begin
            r = pix_ready;
            @(negedge clk);
            cfg_thresh_we = 1'b0;
            if (rand_br) bits_ready = 1'($urandom_range(0, 1));
            if (r) break;
            n++;
            if (n > 500) begin
                errors++;
                $display("FAIL send_timeout: pixel not accepted after %0d cycles", n);
                break;
            end
        end
        pix_valid = 1'b0;
    endtask

    // kind: -1 random data, -2 alternating 200/50, otherwise constant value
    task automatic frame(input int len, input int kind, input bit with_last);
        logic [7:0] d;
        bit we;
        for (int i = 0; i < len; i++) begin
            if (kind == -1)      d = 8'($urandom_range(0, 255));
            else if (kind == -2) d = (i % 2 == 0) ? 8'd200 : 8'd50;
            else                 d = 8'(kind);
            we = rand_gap && ($urandom_range(0, 15) == 0);
            if (rand_gap && $urandom_range(0, 3) == 0) idle(1);
            send(d, with_last && (i == len - 1), we, 8'($urandom_range(0, 255)));
        end
    endtask

    // ---------------- main sequence ----------------
    logic [N_PIX-1:0] alt_pat;
    logic [N_PIX-1:0] ones_pat;

    initial begin
        alt_pat  = 49'h1_5555_5555_5555;
        ones_pat = '1;
        repeat (3) @(negedge clk);
        chk("rst_bits_valid",  64'(bits_valid),  64'd0);
        chk("rst_in_bits",     64'(in_bits),     64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_pix_ready",   64'(pix_ready),   64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Alternating pattern at default threshold.
        bits_ready = 1'b1;
        frame(49, -2, 1'b1);
        chk("alt_valid", 64'(bits_valid), 64'd1);
        chk("alt_bits",  64'(in_bits),    64'(alt_pat));
        @(negedge clk);
        chk("alt_count", 64'(frame_count), 64'd1);

        // Threshold boundary and same-cycle threshold write.
        send(8'd127, 1'b0, 1'b0, 8'd0);
        send(8'd128, 1'b0, 1'b0, 8'd0);
        send(8'd20,  1'b0, 1'b1, 8'd10);
        send(8'd20,  1'b0, 1'b0, 8'd0);
        frame(45, 0, 1'b1);
        chk("thresh_bits", 64'(in_bits[3:0]), 64'b1010);

        // Stalled consumer: second frame waits in HOLD.
        @(negedge clk);
        bits_ready = 1'b0;
        frame(49, 0, 1'b1);
        frame(49, 255, 1'b1);
        chk("hold_ready", 64'(pix_ready),   64'd0);
        chk("hold_bits",  64'(in_bits),     64'd0);
        chk("hold_count", 64'(frame_count), 64'd2);
        bits_ready = 1'b1;
        @(negedge clk);
        bits_ready = 1'b0;
        chk("hold_release_bits",  64'(in_bits),     64'(ones_pat));
        chk("hold_release_ready", 64'(pix_ready),   64'd1);
        chk("hold_release_count", 64'(frame_count), 64'd3);
        bits_ready = 1'b1;
        @(negedge clk);

        // Short frame then a good one.
        frame(11, 255, 1'b1);
        chk("short_err",   64'(frame_err),  64'd1);
        chk("short_valid", 64'(bits_valid), 64'd0);
        frame(49, -1, 1'b1);

        // Long frame with five trailing pixels, then a good one.
        frame(54, -1, 1'b1);
        frame(49, -1, 1'b1);
        idle(2);

        // Reset with one frame on the output and another partly assembled.
        bits_ready = 1'b0;
        frame(49, 255, 1'b1);
        frame(30, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bits_valid),  64'd0);
        chk("mid_rst_bits",  64'(in_bits),     64'd0);
        chk("mid_rst_err",   64'(frame_err),   64'd0);
        chk("mid_rst_count", 64'(frame_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bits_ready = 1'b1;
        @(negedge clk);
        frame(49, -2, 1'b1);
        chk("post_rst_bits", 64'(in_bits), 64'(alt_pat));
        @(negedge clk);
        chk("post_rst_count", 64'(frame_count), 64'd1);

        // Randomized frames, gaps, threshold writes and back-pressure.
        rand_br  = 1'b1;
        rand_gap = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      frame(int'($urandom_range(1, 48)), -1, 1'b1);
            else if (r == 1) frame(int'($urandom_range(50, 55)), -1, 1'b1);
            else             frame(49, -1, 1'b1);
        end
        rand_br  = 1'b0;
        rand_gap = 1'b0;
        bits_ready = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
